// File: rtl/xor_stream_cipher_if.sv
// rtl/xor_stream_cipher_if.sv - serial control/data and ciphertext framing bundle for xor_stream_cipher
interface xor_stream_cipher_if;
    logic en;
    logic data_in;
    logic load_key;
    logic load_msg;
    logic mode;
    logic serial_out;
    logic serial_valid;
    logic serial_start;
    logic serial_end;
    logic key_ready;
    logic busy;
    logic key_missing;

    modport master (
        output en, data_in, load_key, load_msg, mode,
        input  serial_out, serial_valid, serial_start, serial_end, key_ready, busy, key_missing
    );

    modport slave (
        input  en, data_in, load_key, load_msg, mode,
        output serial_out, serial_valid, serial_start, serial_end, key_ready, busy, key_missing
    );
endinterface

// File: rtl/xor_stream_cipher.sv
// rtl/xor_stream_cipher.sv - serial key load and streaming XOR encryption with repeating or LFSR keystream
module xor_stream_cipher #(
    parameter int KEY_BITS = 32,
    parameter int MSG_BITS = 512,
    parameter logic [KEY_BITS-1:0] LFSR_TAPS = KEY_BITS'(32'h80200003)
) (
    input logic iClk,
    input logic iRst,
    xor_stream_cipher_if.slave bus
);
    localparam int KCW = $clog2(KEY_BITS + 1);
    localparam int FCW = $clog2(MSG_BITS + 1);

    typedef enum logic [1:0] {IDLE, KEY_LOAD, FRAME} state_t;

    state_t state, state_nxt;

    logic [KEY_BITS-1:0] key, wk;
    logic [KCW-1:0]      kcnt;
    logic [FCW-1:0]      fcnt;
    logic                mode_q;
    logic                out_bit, valid, start, fin, key_ready, busy, key_missing;

    logic                key_shift, key_done, consume, first, last, miss;
    logic [KEY_BITS-1:0] src;
    logic                src_mode, fb;

    always_comb begin
        state_nxt = state;
        key_shift = 1'b0;
        key_done  = 1'b0;
        consume   = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        miss      = 1'b0;
        if (bus.en) begin
            case (state)
                IDLE: begin
                    if (bus.load_key) begin
                        key_shift = 1'b1;
                        state_nxt = KEY_LOAD;
                    end else if (bus.load_msg && key_ready) begin
                        consume   = 1'b1;
                        first     = 1'b1;
                        last      = (MSG_BITS == 1);
                        state_nxt = last ? IDLE : FRAME;
                    end else if (bus.load_msg) begin
                        miss = 1'b1;
                    end
                end
                KEY_LOAD: begin
                    if (bus.load_key) begin
                        key_shift = 1'b1;
                        if (kcnt == KCW'(KEY_BITS - 1)) begin
                            key_done  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                FRAME: begin
                    if (bus.load_msg) begin
                        consume = 1'b1;
                        last    = (fcnt == FCW'(MSG_BITS - 1));
                        if (last) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The first frame bit runs straight off the loaded key and the live mode pin.
    always_comb begin
        src      = first ? key : wk;
        src_mode = first ? bus.mode : mode_q;
        fb       = src_mode ? ^(src & LFSR_TAPS) : src[KEY_BITS-1];
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            key         <= '0;
            wk          <= '0;
            kcnt        <= '0;
            fcnt        <= '0;
            mode_q      <= 1'b0;
            out_bit     <= 1'b0;
            valid       <= 1'b0;
            start       <= 1'b0;
            fin         <= 1'b0;
            key_ready   <= 1'b0;
            busy        <= 1'b0;
            key_missing <= 1'b0;
        end else begin
            valid <= 1'b0;
            start <= 1'b0;
            fin   <= 1'b0;
            if (key_shift) begin
                key  <= {key[KEY_BITS-2:0], bus.data_in};
                kcnt <= (state == IDLE) ? KCW'(1) : kcnt + 1'b1;
                if (state == IDLE) key_ready <= 1'b0;
            end
            if (key_done) begin
                key_ready   <= 1'b1;
                key_missing <= 1'b0;
            end
            if (miss) key_missing <= 1'b1;
            if (consume) begin
                out_bit <= bus.data_in ^ src[KEY_BITS-1];
                valid   <= 1'b1;
                start   <= first;
                wk      <= {src[KEY_BITS-2:0], fb};
                if (first) mode_q <= bus.mode;
                fin     <= last;
                busy    <= !last;
                fcnt    <= last ? '0 : fcnt + 1'b1;
            end
        end
    end

    assign bus.serial_out   = out_bit;
    assign bus.serial_valid = valid;
    assign bus.serial_start = start;
    assign bus.serial_end   = fin;
    assign bus.key_ready    = key_ready;
    assign bus.busy         = busy;
    assign bus.key_missing  = key_missing;
endmodule

// File: tb/tb_xor_stream_cipher.sv
// tb/tb_xor_stream_cipher.sv - directed-vector bench for xor_stream_cipher
module tb_xor_stream_cipher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [15:0] ct;
    int          nval, gapval, spos, epos;
    logic        busy_mid;

    xor_stream_cipher_if bus ();
    xor_stream_cipher_if b1 ();

    xor_stream_cipher #(.KEY_BITS(8), .MSG_BITS(16), .LFSR_TAPS(8'hB8)) dut (
        .iClk(clk), .iRst(rst), .bus(bus.slave)
    );

    xor_stream_cipher #(.KEY_BITS(8), .MSG_BITS(1), .LFSR_TAPS(8'hB8)) dut1 (
        .iClk(clk), .iRst(rst), .bus(b1.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key_seq(input logic [7:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            bus.load_key = 1'b1;
            bus.data_in  = k[7-i];
            tick();
        end
        bus.load_key = 1'b0;
        bus.data_in  = 1'b0;
        tick();
    endtask

    task automatic run_frame(input logic [15:0] msg, input logic md, input int p_msg, input int p_en,
                             input logic key_inj);
        ct = '0; nval = 0; gapval = 0; spos = 0; epos = 0; busy_mid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.data_in  = msg[15-i];
            bus.load_msg = 1'b1;
            bus.mode     = md;
            bus.load_key = key_inj && (i >= 3) && (i < 11);
            tick();
            if (bus.serial_valid) begin
                ct = {ct[14:0], bus.serial_out};
                nval++;
            end
            if (bus.serial_start) spos = i + 1;
            if (bus.serial_end) epos = i + 1;
            if (i == 7) busy_mid = bus.busy;
            if (i == 5) begin
                bus.load_msg = 1'b0;
                repeat (p_msg) begin
                    tick();
                    if (bus.serial_valid) gapval++;
                end
            end
            if (i == 9) begin
                bus.en = 1'b0;
                repeat (p_en) begin
                    tick();
                    if (bus.serial_valid || bus.serial_start || bus.serial_end) gapval++;
                end
                bus.en = 1'b1;
            end
        end
        bus.load_msg = 1'b0;
        bus.load_key = 1'b0;
        bus.data_in  = 1'b0;
    endtask

    initial begin
        bus.en = 1'b1; bus.data_in = 1'b0; bus.load_key = 1'b0; bus.load_msg = 1'b0; bus.mode = 1'b0;
        b1.en  = 1'b1; b1.data_in  = 1'b0; b1.load_key  = 1'b0; b1.load_msg  = 1'b0; b1.mode  = 1'b0;
        repeat (2) tick();
        check("rst_outputs", {bus.serial_out, bus.serial_valid, bus.serial_start, bus.serial_end,
                              bus.key_ready, bus.busy, bus.key_missing}, 0);
        rst = 1'b0;
        tick();

        nval = 0;
        for (int i = 0; i < 3; i++) begin
            bus.load_msg = 1'b1;
            bus.data_in  = 1'b1;
            tick();
            if (bus.serial_valid) nval++;
        end
        bus.load_msg = 1'b0;
        tick();
        check("nokey_valid", nval, 0);
        check("nokey_missing", bus.key_missing, 1);

        load_key_seq(8'hFF, 4);
        check("partial_key_ready", bus.key_ready, 0);
        check("partial_key_missing", bus.key_missing, 1);

        load_key_seq(8'hA5, 8);
        check("key_ready", bus.key_ready, 1);
        check("key_missing_clr", bus.key_missing, 0);

        run_frame(16'h3C3C, 1'b0, 0, 0, 1'b0);
        check("m0_ct", ct, 16'h9999);
        check("m0_nval", nval, 16);
        check("m0_start_pos", spos, 1);
        check("m0_end_pos", epos, 16);
        check("m0_busy_mid", busy_mid, 1);
        tick();
        check("m0_busy_after", bus.busy, 0);
        check("m0_key_ready", bus.key_ready, 1);

        run_frame(16'h0000, 1'b0, 0, 0, 1'b0);
        check("m0_zero_ct", ct, 16'hA5A5);

        run_frame(16'h0000, 1'b1, 0, 0, 1'b0);
        check("m1_lfsr_ct", ct, 16'hA54E);

        run_frame(16'h3C3C, 1'b0, 5, 3, 1'b0);
        check("pause_ct", ct, 16'h9999);
        check("pause_nval", nval, 16);
        check("pause_gap_valid", gapval, 0);
        check("pause_end_pos", epos, 16);

        run_frame(16'h3C3C, 1'b0, 0, 0, 1'b1);
        check("keyinj_ct", ct, 16'h9999);
        run_frame(16'h3C3C, 1'b0, 0, 0, 1'b0);
        check("after_keyinj_ct", ct, 16'h9999);

        for (int i = 0; i < 8; i++) begin
            b1.load_key = 1'b1;
            b1.data_in  = (8'hA5 >> (7 - i)) & 1'b1;
            tick();
        end
        b1.load_key = 1'b0;
        b1.load_msg = 1'b1;
        b1.data_in  = 1'b0;
        tick();
        check("one_bit_start_end", {b1.serial_valid, b1.serial_start, b1.serial_end, b1.serial_out}, 4'hF);
        check("one_bit_busy", b1.busy, 0);
        b1.data_in = 1'b1;
        tick();
        check("one_bit_second", {b1.serial_valid, b1.serial_start, b1.serial_end, b1.serial_out}, 4'hE);
        b1.load_msg = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            bus.load_msg = 1'b1;
            bus.data_in  = 1'b0;
            tick();
        end
        check("pre_rst_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outputs", {bus.serial_out, bus.serial_valid, bus.serial_start, bus.serial_end,
                                  bus.key_ready, bus.busy, bus.key_missing}, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.load_msg = 1'b0;
        epos = 0;
        repeat (3) begin
            tick();
            if (bus.serial_end || bus.serial_valid) epos++;
        end
        check("rst_no_end", epos, 0);
        bus.load_msg = 1'b1;
        bus.data_in  = 1'b1;
        tick();
        bus.load_msg = 1'b0;
        check("rst_then_valid", bus.serial_valid, 0);
        check("rst_then_missing", bus.key_missing, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/xor_stream_cipher.md
Name: xor_stream_cipher

Overview:
Parametrised, streaming successor to the fixed 32-bit-key / 512-bit-message XOR cipher datapath. It loads a KEY_BITS key serially, then encrypts a serial message frame of MSG_BITS bits on the fly with a one-cycle latency, with no full-message buffer. It adds a selectable keystream mode: a repeating key, or an LFSR-evolved key. It sits between the ui_in serial/control pins and the uo_out serial/framing pins of the top level.

Parameters:
KEY_BITS, 32, key length in bits (>=2)
MSG_BITS, 512, frame length in bits (>=1)
LFSR_TAPS, 32'h80200003, feedback tap mask for mode 1, KEY_BITS wide

Ports:
iClk  input  1  system clock
iRst  input  1  reset, asynchronous, active-high
iEn  input  1  global enable; when low, all state holds and oSerial_valid=0
iData_in  input  1  shared serial data in (key or message bit)
iLoad_key  input  1  key-load qualifier
iLoad_msg  input  1  message-bit qualifier, one bit per cycle
iMode  input  1  0 = repeating key, 1 = LFSR keystream; sampled at frame start
oSerial_out  output  1  ciphertext bit
oSerial_valid  output  1  oSerial_out valid this cycle
oSerial_start  output  1  pulse with first ciphertext bit of a frame
oSerial_end  output  1  pulse with bit MSG_BITS of a frame
oKey_ready  output  1  full key loaded
oBusy  output  1  frame in progress
oKey_missing  output  1  sticky: message bit offered with no key loaded

Behaviour:
- Reset (async, iRst=1): all outputs 0; key, working key (wk) and counters cleared; state IDLE.
- States: IDLE, KEY_LOAD, FRAME. All transitions require iEn=1.
- IDLE and iLoad_key=1: clear the key counter and oKey_ready, shift in the current bit, then go to KEY_LOAD. iLoad_key has priority over iLoad_msg in IDLE, and the message bit is ignored that cycle.
- KEY_LOAD: each cycle with iLoad_key=1, key <= {key[KEY_BITS-2:0], iData_in} (MSB first) and the counter increments.
  - When the counter reaches KEY_BITS: oKey_ready=1, oKey_missing cleared, go to IDLE.
  - iLoad_key dropping early returns to IDLE with oKey_ready=0; the partial key is discarded.
- IDLE, iLoad_msg=1, oKey_ready=0: bit dropped, oKey_missing <= 1, no output.
- IDLE, iLoad_msg=1, oKey_ready=1: start a frame.
  - wk <= key and mode_q <= iMode; the bit is consumed as frame bit 1 using the key MSB.
  - oBusy=1; go to FRAME.
- Each consumed bit (frame start or FRAME with iLoad_msg=1):
  - Next cycle, oSerial_out = iData_in ^ wk[KEY_BITS-1] and oSerial_valid=1.
  - wk <= {wk[KEY_BITS-2:0], fb}, where fb = wk[KEY_BITS-1] in mode 0, or ^(wk & LFSR_TAPS) in mode 1.
  - The frame counter increments; width $clog2(MSG_BITS+1).
- FRAME with iLoad_msg=0: pause; wk and counters hold; oSerial_valid=0 next cycle.
- iLoad_key during FRAME: ignored; the key register is not modified.
- oSerial_start is registered alongside frame bit 1. oSerial_end is registered alongside bit MSG_BITS.
- When bit MSG_BITS is consumed: counter resets to 0, oBusy clears when oSerial_end is asserted, state returns to IDLE. oKey_ready stays 1, so the next frame reuses the key.
- MSG_BITS=1: oSerial_start and oSerial_end assert in the same cycle.
- iEn=0: no state change, no bit consumed; oSerial_valid/start/end deassert next cycle.
- Reset mid-frame: immediate clear; no end pulse; key lost.
- Mode 0 keystream repeats every KEY_BITS bits. Mode 1 emits the key bits first, then LFSR feedback bits.

Test Plan:
- KEY_BITS=8, MSG_BITS=16, mode 0: key 0xA5, message 0x3C3C -> 16 valid bits 0x9999 one cycle after each input; start on bit 1, end on bit 16; oBusy low after the end cycle.
- Same config, mode 0, message 0x0000 -> 0xA5A5. Mode 1, LFSR_TAPS=8'hB8, message 0x0000 -> 0xA54E.
- Message bits before any key load: 3 bits with iLoad_msg=1 -> no oSerial_valid, oKey_missing=1. Then load key 0xA5 -> oKey_missing=0, oKey_ready=1.
- Mid-frame pause: iLoad_msg low for 5 cycles after bit 6, and iEn low for 3 cycles after bit 10 -> ciphertext identical to the unpaused run (0x9999); valid gaps match the pauses.
- iLoad_key pulsed with key 0xFF during a frame -> frame output unchanged. The following frame still uses 0xA5 (message 0x3C3C -> 0x9999).
- Assert iRst at bit 9 -> all outputs 0 within the same cycle, no end pulse; the next message bit sets oKey_missing.
